// File: rtl/uart_rx_framer.sv
// UART 8N1 receive front end: pin synchroniser, frame recovery, one-byte
// holding register with valid/ready handshake, break detection, and
// framing-error / overrun pulses.
module uart_rx_framer #(
  parameter int HALF_BIT   = 52,
  parameter int BREAK_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_break,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BIT_CYC = 2 * HALF_BIT;
  localparam int CW      = $clog2(BIT_CYC);
  localparam int BRK_MAX = BREAK_BITS * BIT_CYC;
  localparam int BW      = $clog2(BRK_MAX + 1);

  localparam logic [CW-1:0] HALF_M1   = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_M1    = CW'(BIT_CYC - 1);
  localparam logic [BW-1:0] BRK_MAX_C = BW'(BRK_MAX);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  // Sequential state
  logic [1:0]    sync_q,      sync_d;
  state_e        state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [2:0]    idx_q,       idx_d;
  logic [7:0]    shift_q,     shift_d;
  logic          valid_q,     valid_d;
  logic [7:0]    data_q,      data_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q,   overrun_d;
  logic [BW-1:0] low_q,       low_d;

  logic rxs;
  logic byte_done;
  logic accept;

  assign rxs    = sync_q[1];
  assign accept = valid_q && rx_ready;

  // Synchroniser shift and break low-time counter (saturating, cleared by high)
  always_comb begin
    sync_d = {sync_q[0], rx};
    low_d  = low_q;
    if (rxs) begin
      low_d = '0;
    end else if (low_q != BRK_MAX_C) begin
      low_d = low_q + BW'(1);
    end
  end

  // Frame recovery FSM: next state, bit timing and data shifting
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    byte_done   = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = HALF_M1;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rxs) begin
          state_d = DATA;
          cnt_d   = BIT_M1;
          idx_d   = 3'd0;
        end else begin
          // Start bit did not survive to mid-bit: a glitch, not a frame.
          state_d = IDLE;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = BIT_M1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rxs) begin
          byte_done = 1'b1;
          state_d   = IDLE;
        end else begin
          // Low stop bit: drop the byte and wait for the line to recover so
          // a break or stuck-low line is not misread as a stream of starts.
          frame_err_d = 1'b1;
          state_d     = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: load on completion when empty or draining this cycle
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = 1'b0;
    if (accept) valid_d = 1'b0;
    if (byte_done) begin
      if (!valid_q || accept) begin
        valid_d = 1'b1;
        data_d  = shift_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: flops are written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      low_q       <= '0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      low_q       <= low_d;
    end
  end

  assign rx_valid  = valid_q;
  assign rx_data   = data_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  // Drops in the very cycle the synchronised line returns high.
  assign rx_break  = (low_q == BRK_MAX_C) && !rxs;

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- UART receive front end that feeds the bootloader protocol state machine.
- Synchronises the raw rx pin, recovers 8N1 frames, and presents bytes on a valid/ready interface through a one-byte holding register.
- Detects a line break and reports it as a level; the protocol FSM uses it as its state-machine reset.
- Also flags framing errors and overruns.

Parameters:
- HALF_BIT, 52, clock cycles per half bit period (CLK_FREQ/(2*baud)); a full bit is 2*HALF_BIT cycles; minimum 2.
- BREAK_BITS, 20, continuous-low duration, in bit periods, that declares a break.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- rx  in  1  asynchronous UART line, idle high
- rx_valid  out  1  holding register contains a byte
- rx_data  out  8  received byte, LSB first on the line
- rx_ready  in  1  consumer accepts the byte when rx_valid && rx_ready
- rx_break  out  1  line held low for at least BREAK_BITS bit periods
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: completed byte dropped because the holding register was full

Behaviour:
- Reset values:
  - rx_valid=0, rx_data=0, rx_break=0, frame_err=0, overrun=0.
  - Synchroniser flops=1, FSM=IDLE, all counters 0.
- Synchroniser: two flops; every decision below uses the second flop output (rxs). Pin-to-rxs latency is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rxs==0 -> START, bit counter = HALF_BIT-1.
- START:
  - Decrement the counter each cycle.
  - At 0, sample rxs.
  - rxs==0 -> DATA, counter = 2*HALF_BIT-1, bit index = 0.
  - rxs==1 -> treat as a glitch and return to IDLE with no output.
- DATA:
  - At counter 0, shift rxs into bit [index], i.e. a right shift with LSB received first.
  - Reload the counter to 2*HALF_BIT-1.
  - After index 7 -> STOP.
- STOP (sample at counter 0):
  - rxs==1 -> byte complete, go to IDLE.
  - rxs==0 -> frame_err pulse for 1 cycle, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rxs==1, then go to IDLE.
  - No new start bit is recognised while in this state.
- Byte completion, on the cycle after the STOP sample:
  - Holding register empty, or being accepted this same cycle (rx_valid && rx_ready) -> rx_data is loaded and rx_valid=1. Simultaneous accept and load keeps rx_valid high with the new byte and is not an overrun.
  - Holding register full and not accepted -> keep the old byte, pulse overrun for 1 cycle.
- Handshake:
  - rx_valid is held until rx_valid && rx_ready.
  - rx_data is stable while rx_valid=1.
  - On acceptance with no new byte, rx_valid goes to 0 on the next edge.
- Break detection:
  - Independent low counter, width ceil(log2(BREAK_BITS*2*HALF_BIT+1)).
  - Increments while rxs==0 and saturates at BREAK_BITS*2*HALF_BIT.
  - Clears to 0 on any cycle with rxs==1.
  - rx_break=1 when the counter is at its saturation value, and falls on the first cycle with rxs==1.
  - A break always also produces one frame_err, because the stop bit samples low.
  - While rx_break=1, the FSM stays in WAIT_HIGH and no bytes are delivered.
- rst asserted mid-frame:
  - The partial byte is discarded and the holding register is cleared.
  - If the line is low when rst releases, the FSM starts a frame from IDLE normally, via START validation.
- Timing from the rx falling edge to rx_valid: 2 (sync) + HALF_BIT + 9*2*HALF_BIT + 1 cycles.

Test Plan:
- Bench settings: HALF_BIT=4, BREAK_BITS=12.
- Frame 0xA5 sent with rx_ready=1 -> rx_valid pulses exactly 1 cycle with rx_data=0xA5, 2+4+72+1=79 cycles after the start edge; frame_err and overrun stay 0.
- Bytes 0x01 then 0x02 back-to-back with rx_ready=0 -> rx_valid=1 with rx_data=0x01, and overrun pulses once at the second completion. Then raise rx_ready -> 0x01 is accepted and rx_valid drops; 0x02 is never presented.
- rx_ready asserted exactly in the completion cycle of a second byte 0x3C while 0x11 is held -> 0x11 is accepted, rx_data=0x3C, rx_valid stays 1, no overrun.
- Low glitch of 3 cycles on idle line -> START validation fails, no rx_valid, no frame_err.
- rx held low for 100 cycles:
  - frame_err pulses once.
  - rx_break=1 from the cycle at which rxs has been low for 96 cycles, i.e. 2+96 cycles after the falling edge.
  - rx_break=0 on the first cycle rxs is high.
  - A following 0x5A frame is received correctly.
- rst pulsed during bit 4 of frame 0xFF while rx_valid holds 0x42 -> all outputs are 0 the next cycle; a subsequent 0x77 frame yields rx_data=0x77 only.
